// File: rtl/mul_issue_unit.sv
// Decode-side initiator for the multiply/divide coprocessor: decodes HI/LO
// instructions in 1a, holds one request in the 2a issue slot, steers MF* results to writeback.
module mul_issue_unit (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst_1a,
    input  logic        inst_valid_1a,
    input  logic [31:0] rs_data_1a,
    input  logic [31:0] rt_data_1a,
    input  logic        flush_2a,
    output logic        is_mul_1a,
    output logic        stall_1a,
    output logic [2:0]  mul__opcode_2a,
    output logic        mul__active_2a,
    output logic [31:0] rs_data_2a,
    output logic [31:0] rt_data_2a,
    input  logic        mul__stall_2a,
    input  logic [31:0] mul__rd_data_3a,
    output logic        wb_valid_3a,
    output logic [4:0]  wb_rd_3a,
    output logic [31:0] wb_data_3a,
    output logic [31:0] stall_cycles,
    output logic [31:0] issued_ops
);

    typedef enum logic [2:0] {
        MUL_MFHI  = 3'd0,
        MUL_MTHI  = 3'd1,
        MUL_MFLO  = 3'd2,
        MUL_MTLO  = 3'd3,
        MUL_MULT  = 3'd4,
        MUL_MULTU = 3'd5,
        MUL_DIV   = 3'd6,
        MUL_DIVU  = 3'd7
    } mul_op_e;

    logic [5:0] funct_1a;
    logic       funct_hit_1a;
    mul_op_e    opcode_1a;
    logic       mf_1a;

    logic       valid_2a;
    mul_op_e    opcode_2a;
    logic [31:0] rs_2a;
    logic [31:0] rt_2a;
    logic [4:0] rd_2a;
    logic       mf_2a;

    logic       accept_2a;

    // ---------------------------------------------------------------- decode
    assign funct_1a = inst_1a[5:0];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        funct_hit_1a = 1'b1;
        opcode_1a    = MUL_MFHI;
        case (funct_1a)
            6'h10:   opcode_1a = MUL_MFHI;
            6'h11:   opcode_1a = MUL_MTHI;
            6'h12:   opcode_1a = MUL_MFLO;
            6'h13:   opcode_1a = MUL_MTLO;
            6'h18:   opcode_1a = MUL_MULT;
            6'h19:   opcode_1a = MUL_MULTU;
            6'h1A:   opcode_1a = MUL_DIV;
            6'h1B:   opcode_1a = MUL_DIVU;
            default: funct_hit_1a = 1'b0;
        endcase
    end

    assign is_mul_1a = inst_valid_1a && (inst_1a[31:26] == 6'd0) && funct_hit_1a;
    assign mf_1a     = (opcode_1a == MUL_MFHI) || (opcode_1a == MUL_MFLO);

    // ------------------------------------------------------------ handshake
    assign mul__active_2a = valid_2a & ~flush_2a;
    assign accept_2a      = mul__active_2a & ~mul__stall_2a;
    assign stall_1a       = mul__active_2a & mul__stall_2a;

    assign mul__opcode_2a = opcode_2a;
    assign rs_data_2a     = rs_2a;
    assign rt_data_2a     = rt_2a;

    // ------------------------------------------------------------ issue slot
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_2a  <= 1'b0;
            opcode_2a <= MUL_MFHI;
            rs_2a     <= '0;
            rt_2a     <= '0;
            rd_2a     <= '0;
            mf_2a     <= 1'b0;
        end else if (flush_2a) begin
            valid_2a  <= 1'b0;
        end else if (!stall_1a) begin
            valid_2a  <= is_mul_1a;
            opcode_2a <= opcode_1a;
            rs_2a     <= rs_data_1a;
            rt_2a     <= rt_data_1a;
            rd_2a     <= inst_1a[15:11];
            mf_2a     <= mf_1a;
        end
    end

    // ------------------------------------------------------------- writeback
    // MF* targeting $0 still issues to the coprocessor but never writes back.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wb_valid_3a <= 1'b0;
            wb_rd_3a    <= '0;
        end else if (accept_2a && mf_2a && (rd_2a != 5'd0)) begin
            wb_valid_3a <= 1'b1;
            wb_rd_3a    <= rd_2a;
        end else begin
            wb_valid_3a <= 1'b0;
        end
    end

    assign wb_data_3a = mul__rd_data_3a;

    // -------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cycles <= '0;
            issued_ops   <= '0;
        end else begin
            if (stall_1a)  stall_cycles <= stall_cycles + 32'd1;
            if (accept_2a) issued_ops   <= issued_ops + 32'd1;
        end
    end

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed bench for mul_issue_unit: issue latency, MF* writeback, stall hold,
// flush-over-stall, non-mul filtering and asynchronous reset mid-stall.
module tb_mul_issue_unit;

    localparam logic [2:0] OP_MFHI  = 3'd0;
    localparam logic [2:0] OP_MFLO  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_MULT  = 3'd4;
    localparam logic [2:0] OP_MULTU = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;

    logic        clk;
    logic        rst_b;
    logic [31:0] inst_1a;
    logic        inst_valid_1a;
    logic [31:0] rs_data_1a;
    logic [31:0] rt_data_1a;
    logic        flush_2a;
    logic        is_mul_1a;
    logic        stall_1a;
    logic [2:0]  mul__opcode_2a;
    logic        mul__active_2a;
    logic [31:0] rs_data_2a;
    logic [31:0] rt_data_2a;
    logic        mul__stall_2a;
    logic [31:0] mul__rd_data_3a;
    logic        wb_valid_3a;
    logic [4:0]  wb_rd_3a;
    logic [31:0] wb_data_3a;
    logic [31:0] stall_cycles;
    logic [31:0] issued_ops;

    int n_checks = 0;
    int n_fail   = 0;

    mul_issue_unit dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .inst_1a         (inst_1a),
        .inst_valid_1a   (inst_valid_1a),
        .rs_data_1a      (rs_data_1a),
        .rt_data_1a      (rt_data_1a),
        .flush_2a        (flush_2a),
        .is_mul_1a       (is_mul_1a),
        .stall_1a        (stall_1a),
        .mul__opcode_2a  (mul__opcode_2a),
        .mul__active_2a  (mul__active_2a),
        .rs_data_2a      (rs_data_2a),
        .rt_data_2a      (rt_data_2a),
        .mul__stall_2a   (mul__stall_2a),
        .mul__rd_data_3a (mul__rd_data_3a),
        .wb_valid_3a     (wb_valid_3a),
        .wb_rd_3a        (wb_rd_3a),
        .wb_data_3a      (wb_data_3a),
        .stall_cycles    (stall_cycles),
        .issued_ops      (issued_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [5:0] funct);
        return {op, 5'd1, 5'd2, rd, 5'd0, funct};
    endfunction

    task automatic idle();
        inst_valid_1a = 1'b0;
        inst_1a       = '0;
        rs_data_1a    = '0;
        rt_data_1a    = '0;
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [5:0] funct,
                         input logic [31:0] rs, input logic [31:0] rt);
        inst_1a       = rtype(6'd0, rd, funct);
        inst_valid_1a = 1'b1;
        rs_data_1a    = rs;
        rt_data_1a    = rt;
    endtask

    initial begin
        rst_b           = 1'b0;
        flush_2a        = 1'b0;
        mul__stall_2a   = 1'b0;
        mul__rd_data_3a = '0;
        idle();
        #12;
        check("rst_active",   32'(mul__active_2a), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_3a),    32'd0);
        check("rst_wb_rd",    32'(wb_rd_3a),       32'd0);
        check("rst_stalls",   stall_cycles,        32'd0);
        check("rst_issued",   issued_ops,          32'd0);
        check("rst_opcode",   32'(mul__opcode_2a), 32'd0);
        check("rst_rs",       rs_data_2a,          32'd0);
        rst_b = 1'b1;

        // MULT rs=3 rt=5: request next cycle, counted after acceptance
        tick();
        drive(5'd0, 6'h18, 32'd3, 32'd5);
        #1;
        check("mult_is_mul", 32'(is_mul_1a), 32'd1);
        tick();
        idle();
        #1;
        check("mult_active", 32'(mul__active_2a), 32'd1);
        check("mult_opcode", 32'(mul__opcode_2a), 32'(OP_MULT));
        check("mult_rs",     rs_data_2a,          32'd3);
        check("mult_rt",     rt_data_2a,          32'd5);
        check("mult_issued_before", issued_ops,   32'd0);
        tick();
        #1;
        check("mult_issued", issued_ops,          32'd1);
        check("mult_idle",   32'(mul__active_2a), 32'd0);

        // MFLO rd=8, coprocessor returns 0x0F
        drive(5'd8, 6'h12, 32'd0, 32'd0);
        tick();
        idle();
        mul__rd_data_3a = 32'h0000_000F;
        #1;
        check("mflo_opcode", 32'(mul__opcode_2a), 32'(OP_MFLO));
        tick();
        #1;
        check("mflo_wb_valid", 32'(wb_valid_3a), 32'd1);
        check("mflo_wb_rd",    32'(wb_rd_3a),    32'd8);
        check("mflo_wb_data",  wb_data_3a,       32'h0000_000F);
        tick();
        #1;
        check("mflo_wb_drop",  32'(wb_valid_3a), 32'd0);

        // MFLO to $0: issued, no writeback
        drive(5'd0, 6'h12, 32'd0, 32'd0);
        tick();
        idle();
        #1;
        check("mflo0_active", 32'(mul__active_2a), 32'd1);
        tick();
        #1;
        check("mflo0_wb_valid", 32'(wb_valid_3a), 32'd0);
        check("mflo0_issued",   issued_ops,       32'd3);

        // MULT then MFHI rd=9, MFHI stalled for 7 cycles
        tick();
        drive(5'd0, 6'h18, 32'd1, 32'd2);
        tick();
        drive(5'd9, 6'h10, 32'd0, 32'd0);
        #1;
        check("pair_mult_opcode", 32'(mul__opcode_2a), 32'(OP_MULT));
        tick();
        idle();
        mul__stall_2a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("stall_hold_stall1a", 32'(stall_1a),       32'd1);
            check("stall_hold_opcode",  32'(mul__opcode_2a), 32'(OP_MFHI));
            check("stall_count_run",    stall_cycles,        32'(i));
            tick();
        end
        mul__stall_2a = 1'b0;
        #1;
        check("stall_released",   32'(stall_1a),       32'd0);
        check("stall_active",     32'(mul__active_2a), 32'd1);
        check("stall_cycles_7",   stall_cycles,        32'd7);
        check("stall_no_wb_yet",  32'(wb_valid_3a),    32'd0);
        tick();
        #1;
        check("mfhi_wb_valid", 32'(wb_valid_3a), 32'd1);
        check("mfhi_wb_rd",    32'(wb_rd_3a),    32'd9);
        check("pair_issued",   issued_ops,       32'd5);

        // DIV stalled, flushed on the 3rd stall cycle
        drive(5'd0, 6'h1A, 32'd100, 32'd7);
        tick();
        idle();
        mul__stall_2a = 1'b1;
        #1;
        check("div_stall1a", 32'(stall_1a),       32'd1);
        check("div_opcode",  32'(mul__opcode_2a), 32'(OP_DIV));
        tick();
        tick();
        flush_2a = 1'b1;
        #1;
        check("flush_same_active",  32'(mul__active_2a), 32'd0);
        check("flush_same_stall1a", 32'(stall_1a),       32'd0);
        tick();
        flush_2a = 1'b0;
        #1;
        check("flush_next_active",  32'(mul__active_2a), 32'd0);
        check("flush_next_stall1a", 32'(stall_1a),       32'd0);
        check("flush_issued",       issued_ops,          32'd5);
        check("flush_stall_cycles", stall_cycles,        32'd9);
        mul__stall_2a = 1'b0;

        // Non-mul instructions are ignored
        tick();
        drive(5'd4, 6'h21, 32'd1, 32'd1);
        #1;
        check("addu_is_mul", 32'(is_mul_1a), 32'd0);
        inst_1a = rtype(6'h23, 5'd4, 6'h18);
        #1;
        check("nonspecial_is_mul", 32'(is_mul_1a), 32'd0);
        inst_1a = rtype(6'd0, 5'd4, 6'h1C);
        #1;
        check("funct1c_is_mul", 32'(is_mul_1a), 32'd0);
        inst_1a       = rtype(6'd0, 5'd4, 6'h18);
        inst_valid_1a = 1'b0;
        #1;
        check("invalid_is_mul", 32'(is_mul_1a), 32'd0);
        inst_1a       = rtype(6'd0, 5'd4, 6'h21);
        inst_valid_1a = 1'b1;
        tick();
        idle();
        flush_2a = 1'b1;
        #1;
        check("addu_active", 32'(mul__active_2a), 32'd0);
        tick();
        flush_2a = 1'b0;
        #1;
        check("empty_flush_active", 32'(mul__active_2a), 32'd0);
        check("empty_flush_issued", issued_ops,          32'd5);

        // Asynchronous reset while a MULTU is stalled
        drive(5'd0, 6'h19, 32'd7, 32'd8);
        tick();
        idle();
        mul__stall_2a = 1'b1;
        #1;
        check("multu_stall1a", 32'(stall_1a),       32'd1);
        check("multu_opcode",  32'(mul__opcode_2a), 32'(OP_MULTU));
        tick();
        rst_b = 1'b0;
        #1;
        check("arst_active",   32'(mul__active_2a), 32'd0);
        check("arst_stall1a",  32'(stall_1a),       32'd0);
        check("arst_stalls",   stall_cycles,        32'd0);
        check("arst_issued",   issued_ops,          32'd0);
        check("arst_opcode",   32'(mul__opcode_2a), 32'd0);
        check("arst_rs",       rs_data_2a,          32'd0);
        check("arst_wb_valid", 32'(wb_valid_3a),    32'd0);
        check("arst_wb_rd",    32'(wb_rd_3a),       32'd0);
        #1;
        rst_b         = 1'b1;
        mul__stall_2a = 1'b0;
        tick();
        #1;
        check("post_rst_idle1", 32'(mul__active_2a), 32'd0);
        tick();
        #1;
        check("post_rst_idle2",   32'(mul__active_2a), 32'd0);
        check("post_rst_issued",  issued_ops,          32'd0);
        drive(5'd0, 6'h13, 32'h0000_ABCD, 32'd0);
        tick();
        idle();
        #1;
        check("mtlo_active", 32'(mul__active_2a), 32'd1);
        check("mtlo_opcode", 32'(mul__opcode_2a), 32'(OP_MTLO));
        check("mtlo_rs",     rs_data_2a,          32'h0000_ABCD);
        tick();
        #1;
        check("mtlo_issued", issued_ops, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issue_unit.md
# mul_issue_unit

Pipeline-side initiator for the multiply/divide coprocessor. It decodes SPECIAL-class HI/LO instructions in stage 1a and registers them into a 2a issue slot that drives the coprocessor request interface. The issue slot holds its request while the coprocessor reports a stall. MFHI/MFLO results from 3a are steered to the register-file writeback path. Sits between the decode stage and the coprocessor, replacing ad-hoc request logic in the core.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_b  in  1  reset; asynchronous, active-low
- inst_1a  in  32  instruction in decode
- inst_valid_1a  in  1  inst_1a is a live instruction
- rs_data_1a, rt_data_1a  in  32 each  register-file operands for inst_1a
- flush_2a  in  1  squash the 2a slot this cycle
- is_mul_1a  out  1  inst_1a is one of the eight HI/LO instructions (combinational)
- stall_1a  out  1  upstream must hold 1a (combinational)
- mul__opcode_2a  out  3  coprocessor opcode, shared MUL_* encodings
- mul__active_2a  out  1  request valid
- rs_data_2a, rt_data_2a  out  32 each  request operands
- mul__stall_2a  in  1  coprocessor cannot accept this cycle
- mul__rd_data_3a  in  32  MFHI/MFLO result
- wb_valid_3a  out  1  write wb_data_3a to register wb_rd_3a
- wb_rd_3a  out  5  destination register
- wb_data_3a  out  32  equals mul__rd_data_3a
- stall_cycles  out  32  count of cycles with a stalled request
- issued_ops  out  32  count of accepted requests

## Operation
- Decode:
  - is_mul_1a = inst_valid_1a & inst_1a[31:26]==0 & funct ∈ {0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU}.
  - Each funct maps to the matching MUL_* opcode.
  - Other instructions are ignored.
- 2a slot registers: valid_2a, opcode_2a, rs_2a, rt_2a, rd_2a (inst[15:11]), mf_2a (MFHI/MFLO).
- mul__active_2a = valid_2a & ~flush_2a.
- accept = mul__active_2a & ~mul__stall_2a.
- stall_1a = mul__active_2a & mul__stall_2a.
- Slot update, first match wins:
  1. flush_2a: valid_2a←0.
  2. stall_1a: hold all slot fields.
  3. Otherwise: load from 1a, with valid_2a←is_mul_1a.
- When valid_2a=0, opcode/operand outputs are don't-care.
- 3a stage:
  - On accept with mf_2a & rd_2a≠0: wb_valid_3a←1, wb_rd_3a←rd_2a.
  - Else wb_valid_3a←0.
  - MF* to $0 is issued but produces no writeback.
- wb_data_3a = mul__rd_data_3a, combinational passthrough.
- Counters, both wrap modulo 2^32:
  - stall_cycles increments every cycle stall_1a=1.
  - issued_ops increments every cycle accept=1.

## Timing
- Reset values:
  - valid_2a, mul__active_2a, wb_valid_3a = 0.
  - wb_rd_3a = 0; both counters = 0.
  - Operand and opcode registers = 0.
- Latency:
  - Instruction in 1a at cycle N → request visible at N+1.
  - If accepted at N+1, MF* writeback is valid at N+2.
- Handshake:
  - A request is consumed only on the cycle accept=1.
  - While stalled, opcode and operands are stable and stall_1a=1.
  - 1a contents are not lost: upstream holds them.
- Flush and stall in the same cycle: flush wins, the slot empties, and stall_1a=0 that cycle.
- Flush on a cycle with no valid slot: no effect.
- Back-to-back accepts: each cycle may accept one op. The coprocessor stalls the successor as needed.
- Reset mid-stall: slot clears immediately and no request is re-issued.

## Test plan
- MULT (funct 0x18, rs=3, rt=5) valid at cycle 0, no stall:
  - Cycle 1: active=1, opcode=MUL_MULT, rs_data_2a=3, rt_data_2a=5.
  - Cycle 2: issued_ops=1 and active=0.
- MFLO rd=8 at cycle 0, coprocessor returns 0x0000000F:
  - Cycle 2: wb_valid_3a=1, wb_rd_3a=8, wb_data_3a=0x0F.
  - Same with rd=0: wb_valid_3a stays 0.
- MULT then MFHI on consecutive cycles, with mul__stall_2a high for 7 cycles on the MFHI:
  - stall_1a high for 7 cycles with opcode=MUL_MFHI held.
  - stall_cycles=7.
  - Writeback occurs one cycle after the stall drops.
- Stalled DIV with flush_2a at the 3rd stall cycle:
  - Next cycle active=0, stall_1a=0.
  - issued_ops does not increment for the DIV.
- Non-mul instruction (ADDU, funct 0x21) valid:
  - is_mul_1a=0 and active never asserts.
- rst_b pulsed low while a request is stalled:
  - All outputs return to their reset values asynchronously.
  - No request appears after reset release until a new is_mul_1a.
